// File: rtl/jtag_scan_seq.sv
// Host-side JTAG TMS/TDI sequencer: runs one scan command at a time and returns the captured TDO bits.
// Optional JTAG_SEQ_STATE_MIRROR_EN adds a tap_state output that tracks the TAP controller state.
module jtag_scan_seq #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tclk,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic               tdo,
  output logic               tms,
  output logic               tdi,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data
`ifdef JTAG_SEQ_STATE_MIRROR_EN
  ,
  output logic [3:0]         tap_state
`endif
);

  typedef enum logic [3:0] {
    PORST, RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE,
    SHIFT, EXIT1, UPDATE, RTI, HOLD, DONE
  } state_t;

  localparam logic [1:0] OP_DR   = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  state_t             state, state_n;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic [1:0]         op_r;
  logic [LEN_W-1:0]   len_r;
  logic               err_r;
  logic [MAX_LEN-1:0] sh_r;
  logic [MAX_LEN-1:0] cap_r;
  logic               tms_n, tdi_n, shift_step;
  logic               accept, len_bad;

  assign accept  = cmd_valid & cmd_ready;
  assign len_bad = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tms_n      = 1'b0;
    tdi_n      = 1'b0;
    shift_step = 1'b0;
    case (state)
      PORST: begin
        state_n = RST_SEQ;
        cnt_n   = LEN_W'(1);
        tms_n   = 1'b1;
      end
      RST_SEQ: begin
        if (cnt == LEN_W'(5)) begin
          state_n = RTI;
        end else begin
          cnt_n = cnt + LEN_W'(1);
          tms_n = 1'b1;
        end
      end
      // The power-on sequence and the RESET command share this path; only the command responds.
      RTI: state_n = (op_r == OP_RST) ? DONE : IDLE;
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        case (op_r)
          OP_IDLE: begin
            if (cnt == len_r) state_n = DONE;
            else cnt_n = cnt + LEN_W'(1);
          end
          OP_RST: begin
            state_n = RST_SEQ;
            cnt_n   = LEN_W'(1);
            tms_n   = 1'b1;
          end
          default: begin
            if (err_r) begin
              state_n = DONE;
            end else begin
              state_n = SEL_DR;
              tms_n   = 1'b1;
            end
          end
        endcase
      end
      SEL_DR: begin
        cnt_n = '0;
        if (op_r == OP_IR) begin
          state_n = SEL_IR;
          tms_n   = 1'b1;
        end else begin
          state_n = CAPTURE;
        end
      end
      SEL_IR: begin
        state_n = CAPTURE;
        cnt_n   = '0;
      end
      CAPTURE: begin
        if (cnt == '0) begin
          cnt_n = LEN_W'(1);
        end else begin
          state_n    = SHIFT;
          cnt_n      = '0;
          tdi_n      = sh_r[0];
          tms_n      = (len_r == LEN_W'(1));
          shift_step = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == len_r - LEN_W'(1)) begin
          state_n = EXIT1;
          tms_n   = 1'b1;
        end else begin
          cnt_n      = cnt + LEN_W'(1);
          tdi_n      = sh_r[0];
          tms_n      = (cnt + LEN_W'(2) == len_r);
          shift_step = 1'b1;
        end
      end
      EXIT1:   state_n = UPDATE;
      UPDATE:  state_n = DONE;
      default: begin
        state_n = PORST;
        tms_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      state     <= PORST;
      cnt       <= '0;
      op_r      <= OP_IDLE;
      len_r     <= '0;
      err_r     <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tms       <= tms_n;
      tdi       <= tdi_n;
      cmd_ready <= (state_n == IDLE) || (state_n == DONE);
      rsp_valid <= (state_n == DONE);
      rsp_err   <= (state_n == DONE) && err_r;
      if (accept) begin
        op_r     <= cmd_op;
        len_r    <= cmd_len;
        err_r    <= ~cmd_op[1] && len_bad;
        rsp_data <= '0;
      end else if (state_n == DONE) begin
        rsp_data <= cap_r;
      end
    end
  end

  // TDO for the bit presented in the previous cycle lands at index cnt.
  always_ff @(posedge tclk) begin
    if (accept) begin
      sh_r  <= cmd_data;
      cap_r <= '0;
    end else begin
      if (shift_step) sh_r <= sh_r >> 1;
      if (state == SHIFT) cap_r <= cap_r | (MAX_LEN'(tdo) << cnt);
    end
  end

`ifdef JTAG_SEQ_STATE_MIRROR_EN
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      4'hF: tap_next = t ? 4'hF : 4'hC;
      4'hC: tap_next = t ? 4'h7 : 4'hC;
      4'h7: tap_next = t ? 4'h4 : 4'h6;
      4'h6: tap_next = t ? 4'h1 : 4'h2;
      4'h2: tap_next = t ? 4'h1 : 4'h2;
      4'h1: tap_next = t ? 4'h5 : 4'h3;
      4'h3: tap_next = t ? 4'h0 : 4'h3;
      4'h0: tap_next = t ? 4'h5 : 4'h2;
      4'h5: tap_next = t ? 4'h7 : 4'hC;
      4'h4: tap_next = t ? 4'hF : 4'hE;
      4'hE: tap_next = t ? 4'h9 : 4'hA;
      4'hA: tap_next = t ? 4'h9 : 4'hA;
      4'h9: tap_next = t ? 4'hD : 4'hB;
      4'hB: tap_next = t ? 4'h8 : 4'hB;
      4'h8: tap_next = t ? 4'hD : 4'hA;
      default: tap_next = t ? 4'h7 : 4'hC;
    endcase
  endfunction

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) tap_state <= 4'hF;
    else      tap_state <= tap_next(tap_state, tms_n);
  end
`endif

endmodule

// File: doc/jtag_scan_seq.md
Name: jtag_scan_seq

Overview:
- TMS/TDI sequencer that drives the tap state machine from the host side.
- Accepts one scan command at a time: shift-DR, shift-IR, TAP reset, or idle hold.
- Generates the tms/tdi bit stream on tclk and captures tdo during shift states.
- Returns captured bits through a single-cycle response pulse; sits between the debug command source and the tap block.

Parameters:
- MAX_LEN, 32, maximum scan length in bits; width of cmd_data/rsp_data.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- tclk  in  1  scan clock; all logic on its rising edge
- trst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle and able to accept
- cmd_op  in  2  00 SHIFT_DR, 01 SHIFT_IR, 10 RESET, 11 IDLE
- cmd_len  in  LEN_W  bit count (shift ops) or cycle count (IDLE)
- cmd_data  in  MAX_LEN  TDI bits, bit 0 shifted first
- tdo  in  1  serial data from scan chain
- tms  out  1  to tap.tms
- tdi  out  1  serial data to scan chain
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: illegal length
- rsp_data  out  MAX_LEN  captured tdo bits, bit k = k-th shifted bit

Behaviour:
- trst high, asynchronously: tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, FSM in PORST.
- After trst deasserts: automatic reset sequence (5×tms=1, then 1×tms=0); cmd_ready rises the edge after the final tms=0. No rsp_valid is issued for this sequence.
- Handshake:
  - Command accepted on an edge with cmd_valid & cmd_ready; that edge is edge 0.
  - cmd_ready drops at edge 0 and stays low until rsp_valid.
  - cmd_* is sampled only at acceptance.
- All outputs are registered. The value presented at edge n is consumed by tap at edge n+1.
- While idle: tms=0 and tdi=0, holding tap in Run-Test/Idle.
- FSM states: PORST, RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI, HOLD, DONE.
- SHIFT_DR, len N:
  - tms sequence 1,0,0 presented at edges 1..3.
  - Shift bits presented at edges 4..N+3: tdi=cmd_data[k], tms=0, except the last bit, which has tms=1.
  - tms=1 (update) at edge N+4; tms=0 (idle) at edge N+5.
  - tdo for bit k is sampled at edge 5+k.
  - rsp_valid and cmd_ready rise at edge N+6.
- SHIFT_IR: identical to SHIFT_DR with one extra leading tms=1 (1,1,0,0); every later edge index is +1.
- RESET: tms=1 at edges 1..5, tms=0 at edge 6; rsp_valid at edge 7 with rsp_data=0.
- IDLE, len M: tms=0 for M edges (edges 1..M); rsp_valid at edge M+1. M=0 gives rsp_valid at edge 1.
- Length errors:
  - A shift op with len=0 or len>MAX_LEN generates no TAP activity; rsp_valid and rsp_err rise at edge 1.
  - IDLE with M>MAX_LEN is legal.
- rsp_data:
  - Bits ≥ N are zero.
  - Held until the next command is accepted, then cleared.
  - rsp_err clears the cycle after rsp_valid.
- tdi returns to 0 outside SHIFT.
- trst asserted mid-command: command aborted immediately, no response, power-on reset sequence reruns after deassertion.
- cmd_valid while busy is ignored, not queued.

Optional Feature:
- Macro JTAG_SEQ_STATE_MIRROR_EN.
- When defined: adds output tap_state [3:0], the sequencer's model of the TAP state after the currently presented tms is consumed. Encoding uses IEEE 1149.1 codes (TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, UpdIR=D). Reset value F.
- When undefined: port absent, no mirror logic.

Test Plan:
- Release trst at t0 → tms trace 1,1,1,1,1,0; cmd_ready high on the 7th edge; no rsp_valid.
- SHIFT_DR, len=4, data=4'b1011, tdo looped to tdi via a 1-cycle delay → tms 1,0,0,0,0,0,1,1,0; tdi 1,1,0,1; rsp_valid at edge 10; rsp_data=4'b1011.
- SHIFT_IR, len=5, tdo tied 1 → tms 1,1,0,0,0,0,0,0,1,1,0; rsp_valid at edge 12; rsp_data=32'h1F.
- SHIFT_DR with len=0, then len=33 → each gives rsp_valid+rsp_err at edge 1; tms stays 0.
- trst pulsed at edge 3 of a SHIFT_DR len 8 → outputs go to reset values immediately; no rsp_valid; full reset sequence rerun.
- With JTAG_SEQ_STATE_MIRROR_EN: shift-DR scan → tap_state F,C,…,7,6,2,…,1,5,C, matching tap's one-hot outputs edge-for-edge.
